ped_request_scheduler: RTL

//  Conditions the two pedestrian push-buttons and schedules pedestrian service for the traffic light controller.

---
 rtl/ped_request_scheduler.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/ped_request_scheduler.sv
// Pedestrian button conditioning and round-robin walk scheduling for the traffic light controller.
// Buttons are synchronised, debounced and latched. Pending requests are granted one at a time over req/ack.
module ped_request_scheduler #(
    parameter int unsigned CNT_W           = 32,
    parameter int unsigned DEBOUNCE_CYCLES = 500_000,
    parameter int unsigned WALK_TIME       = 350_000_000,
    parameter int unsigned CLEAR_TIME      = 100_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic ns_button,
    input  logic ew_button,
    input  logic hold,
    input  logic serve_ack,
    output logic serve_req,
    output logic serve_dir,
    output logic walk_ns,
    output logic walk_ew,
    output logic ns_pending,
    output logic ew_pending
);

    // state   | meaning
    // S_IDLE  | waiting for a pending request while hold is low
    // S_REQ   | serve_req raised toward the controller, waiting for serve_ack
    // S_WALK  | walk output for last_dir asserted, phase counter running
    // S_CLEAR | clearance interval, no walk, phase counter running
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_WALK  = 2'd2;
    localparam logic [1:0] S_CLEAR = 2'd3;

    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WALK_LAST  = CNT_W'(WALK_TIME - 1);
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_TIME - 1);

    // Channel index 0 is NS, 1 is EW, matching the serve_dir encoding.
    logic [1:0]       r_sync0;
    logic [1:0]       r_sync1;
    logic [1:0]       r_stable;
    logic [1:0]       r_stable_d;
    logic [CNT_W-1:0] r_db_cnt [2];
    logic [1:0]       r_pending;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_phase_cnt;
    logic             r_last_dir;
    logic             r_serve_req;
    logic             r_serve_dir;
    logic             r_walk_ns;
    logic             r_walk_ew;

    logic [1:0] w_press;
    logic [1:0] w_pending_nxt;
    logic       w_in_service;
    logic       w_ack_take;
    logic       w_sel;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync0    <= '0;
            r_sync1    <= '0;
            r_stable   <= '0;
            r_stable_d <= '0;
            for (int i = 0; i < 2; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_sync0    <= {ew_button, ns_button};
            r_sync1    <= r_sync0;
            r_stable_d <= r_stable;
            for (int i = 0; i < 2; i++) begin
                if (r_sync1[i] == r_stable[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_stable[i] <= r_sync1[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign w_press      = r_stable & ~r_stable_d;
    assign w_in_service = (r_state == S_WALK) || (r_state == S_CLEAR);
    assign w_ack_take   = (r_state == S_REQ) && serve_ack;
    assign w_sel        = (r_pending == 2'b11) ? ~r_last_dir : r_pending[1];

    // The ack clear beats a same-cycle press; presses for the direction being served are dropped.
    always_comb begin
        w_pending_nxt = r_pending;
        for (int i = 0; i < 2; i++) begin
            if (w_ack_take && (r_serve_dir == i[0])) begin
                w_pending_nxt[i] = 1'b0;
            end else if (w_press[i] && !(w_in_service && (r_last_dir == i[0]))) begin
                w_pending_nxt[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending   <= '0;
            r_state     <= S_IDLE;
            r_phase_cnt <= '0;
            r_last_dir  <= 1'b1;
            r_serve_req <= 1'b0;
            r_serve_dir <= 1'b0;
            r_walk_ns   <= 1'b0;
            r_walk_ew   <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            case (r_state)
                S_IDLE: begin
                    if (!hold && (r_pending != 2'b00)) begin
                        r_serve_req <= 1'b1;
                        r_serve_dir <= w_sel;
                        r_state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (serve_ack) begin
                        r_last_dir  <= r_serve_dir;
                        r_serve_req <= 1'b0;
                        r_phase_cnt <= WALK_LAST;
                        r_walk_ns   <= ~r_serve_dir;
                        r_walk_ew   <= r_serve_dir;
                        r_state     <= S_WALK;
                    end else if (hold) begin
                        r_serve_req <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                S_WALK: begin
                    if (hold) begin
                        r_walk_ns   <= 1'b0;
                        r_walk_ew   <= 1'b0;
                        r_phase_cnt <= '0;
                        r_state     <= S_IDLE;
                    end else if (r_phase_cnt == '0) begin
                        r_walk_ns   <= 1'b0;
                        r_walk_ew   <= 1'b0;
                        r_phase_cnt <= CLEAR_LAST;
                        r_state     <= S_CLEAR;
                    end else begin
                        r_phase_cnt <= r_phase_cnt - CNT_W'(1);
                    end
                end
                S_CLEAR: begin
                    if (hold || (r_phase_cnt == '0)) begin
                        r_phase_cnt <= '0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_phase_cnt <= r_phase_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign serve_req  = r_serve_req;
    assign serve_dir  = r_serve_dir;
    assign walk_ns    = r_walk_ns;
    assign walk_ew    = r_walk_ew;
    assign ns_pending = r_pending[0];
    assign ew_pending = r_pending[1];

endmodule
